// File: rtl/spi_motor_command_slave_pkg.sv
// Shared types and constants for the SPI motor-command link.
package spi_motor_command_slave_pkg;

    localparam int unsigned SPI_WORD_WIDTH = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StCheck = 2'd2
    } state_e;

    // Total number of bits in one full frame.
    function automatic int unsigned frame_bits(input int unsigned num_words,
                                               input int unsigned word_width);
        return num_words * word_width;
    endfunction

endpackage

// File: rtl/spi_motor_command_slave_if.sv
// SPI pin bundle between the MCU (master) and the FPGA (slave).
interface spi_motor_command_slave_if;

    logic spi_sck;
    logic spi_cs_n;
    logic spi_mosi;
    logic spi_miso;

    modport master (output spi_sck, output spi_cs_n, output spi_mosi, input spi_miso);
    modport slave  (input spi_sck, input spi_cs_n, input spi_mosi, output spi_miso);

endinterface

// File: rtl/spi_motor_command_slave_sync_edge.sv
// Two-flop synchronizer for one asynchronous input, with rise/fall pulses on the synced level.
module spi_motor_command_slave_sync_edge (
    input  logic clock,
    input  logic reset_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Reset to 0 so a line already low at reset release never produces a fall pulse.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_motor_command_slave.sv
// SPI slave: receives per-motor duty/direction words, returns hall counts, watchdog on duty.
module spi_motor_command_slave
    import spi_motor_command_slave_pkg::*;
#(
    parameter int unsigned NUM_MOTORS       = 5,
    parameter int unsigned WORD_WIDTH       = SPI_WORD_WIDTH,
    parameter int unsigned DUTY_CYCLE_WIDTH = 10,
    parameter int unsigned WATCHDOG_CYCLES  = 1_000_000
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    spi_motor_command_slave_if.slave               spi,
    input  logic [NUM_MOTORS*WORD_WIDTH-1:0]       hall_count,
    output logic [NUM_MOTORS*DUTY_CYCLE_WIDTH-1:0] duty_cycle,
    output logic [NUM_MOTORS-1:0]                  direction,
    output logic                                   update,
    output logic                                   frame_error,
    output logic                                   watchdog_trip
);

    localparam int unsigned FrameBits = frame_bits(NUM_MOTORS, WORD_WIDTH);
    localparam int unsigned CntWidth  = $clog2(FrameBits + 2);
    localparam int unsigned WdWidth   = $clog2(WATCHDOG_CYCLES + 1);

    logic sck_level, sck_rise, sck_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level, mosi_rise, mosi_fall;

    spi_motor_command_slave_sync_edge u_sync_sck (
        .clock(clock), .reset_n(reset_n), .async_in(spi.spi_sck),
        .level(sck_level), .rise(sck_rise), .fall(sck_fall)
    );
    spi_motor_command_slave_sync_edge u_sync_cs (
        .clock(clock), .reset_n(reset_n), .async_in(spi.spi_cs_n),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );
    spi_motor_command_slave_sync_edge u_sync_mosi (
        .clock(clock), .reset_n(reset_n), .async_in(spi.spi_mosi),
        .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
    );

    state_e                                 state_q;
    logic [CntWidth-1:0]                    bit_cnt_q;
    logic                                   overrun_q;
    logic [FrameBits-1:0]                   rx_q;
    logic [FrameBits-1:0]                   tx_q;
    logic                                   miso_q;
    logic [WdWidth-1:0]                     wd_cnt_q;
    logic [FrameBits-1:0]                   tx_snapshot;
    logic [NUM_MOTORS*DUTY_CYCLE_WIDTH-1:0] rx_duty;
    logic [NUM_MOTORS-1:0]                  rx_dir;

    // Word 0 is shifted first, so it sits in the top of the frame-ordered buffers.
    always_comb begin
        tx_snapshot = '0;
        rx_duty     = '0;
        rx_dir      = '0;
        for (int k = 0; k < NUM_MOTORS; k++) begin
            tx_snapshot[(NUM_MOTORS-1-k)*WORD_WIDTH +: WORD_WIDTH] =
                hall_count[k*WORD_WIDTH +: WORD_WIDTH];
            rx_duty[k*DUTY_CYCLE_WIDTH +: DUTY_CYCLE_WIDTH] =
                rx_q[(NUM_MOTORS-1-k)*WORD_WIDTH +: DUTY_CYCLE_WIDTH];
            rx_dir[k] = rx_q[(NUM_MOTORS-1-k)*WORD_WIDTH + WORD_WIDTH - 1];
        end
    end

    // Frame FSM, shift registers, committed outputs and watchdog.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            bit_cnt_q     <= '0;
            overrun_q     <= 1'b0;
            rx_q          <= '0;
            tx_q          <= '0;
            miso_q        <= 1'b0;
            wd_cnt_q      <= '0;
            duty_cycle    <= '0;
            direction     <= '0;
            update        <= 1'b0;
            frame_error   <= 1'b0;
            watchdog_trip <= 1'b1;
        end else begin
            update      <= 1'b0;
            frame_error <= 1'b0;

            // Expiry zeroes duty only; a commit in CHECK below overrides this.
            if (wd_cnt_q != '0) begin
                wd_cnt_q <= wd_cnt_q - 1'b1;
                if (wd_cnt_q == WdWidth'(1)) begin
                    watchdog_trip <= 1'b1;
                    duty_cycle    <= '0;
                end
            end

            unique case (state_q)
                StIdle: begin
                    miso_q <= 1'b0;
                    if (cs_fall) begin
                        state_q   <= StShift;
                        tx_q      <= tx_snapshot;
                        miso_q    <= tx_snapshot[FrameBits-1];
                        bit_cnt_q <= '0;
                        overrun_q <= 1'b0;
                        rx_q      <= '0;
                    end
                end
                StShift: begin
                    if (cs_rise) begin
                        state_q <= StCheck;
                    end
                    if (sck_rise) begin
                        if (bit_cnt_q < CntWidth'(FrameBits)) begin
                            rx_q <= {rx_q[FrameBits-2:0], mosi_level};
                        end else begin
                            overrun_q <= 1'b1;
                        end
                        if (bit_cnt_q != CntWidth'(FrameBits + 1)) begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                    // Zeros shift in behind the data, so miso idles low past the last bit.
                    if (sck_fall) begin
                        tx_q   <= {tx_q[FrameBits-2:0], 1'b0};
                        miso_q <= tx_q[FrameBits-2];
                    end
                end
                StCheck: begin
                    state_q <= StIdle;
                    miso_q  <= 1'b0;
                    if (bit_cnt_q == CntWidth'(FrameBits) && !overrun_q) begin
                        duty_cycle    <= rx_duty;
                        direction     <= rx_dir;
                        update        <= 1'b1;
                        wd_cnt_q      <= WdWidth'(WATCHDOG_CYCLES);
                        watchdog_trip <= 1'b0;
                    end else begin
                        frame_error <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Gate with the raw pin so miso is low the moment chip select is released.
    assign spi.spi_miso = miso_q & ~spi.spi_cs_n;

    logic unused_sync;
    assign unused_sync = ^{sck_level, cs_level, mosi_rise, mosi_fall};

endmodule

// File: tb/tb_spi_motor_command_slave.sv
// Randomized bench for spi_motor_command_slave with a frame-level reference model.
module tb_spi_motor_command_slave;

    localparam int NM = 5;
    localparam int WW = 16;
    localparam int DW = 10;
    localparam int WD = 100;
    localparam int FB = NM * WW;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [NM*WW-1:0]  hall_count;
    logic [NM*DW-1:0]  duty_cycle;
    logic [NM-1:0]     direction;
    logic              update;
    logic              frame_error;
    logic              watchdog_trip;

    spi_motor_command_slave_if spi ();

    spi_motor_command_slave #(
        .NUM_MOTORS(NM), .WORD_WIDTH(WW), .DUTY_CYCLE_WIDTH(DW), .WATCHDOG_CYCLES(WD)
    ) dut (
        .clock(clock), .reset_n(reset_n), .spi(spi), .hall_count(hall_count),
        .duty_cycle(duty_cycle), .direction(direction), .update(update),
        .frame_error(frame_error), .watchdog_trip(watchdog_trip)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int          upd_total = 0;
    int          err_total = 0;
    int unsigned last_upd_cyc = 0;
    always @(negedge clock) begin
        if (update) begin
            upd_total++;
            last_upd_cyc = cyc;
        end
        if (frame_error) err_total++;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: last committed words, and when (if ever) the last commit happened.
    logic [DW-1:0] m_duty [NM];
    logic [NM-1:0] m_dir;
    bit            m_ever;
    int unsigned   m_commit_cyc;
    logic [WW-1:0] tx_words [NM];
    logic [WW-1:0] hall_snap [NM];
    logic [FB-1:0] miso_bits;

    task automatic model_reset();
        for (int k = 0; k < NM; k++) m_duty[k] = '0;
        m_dir  = '0;
        m_ever = 0;
    endtask

    task automatic check_state(input string tag);
        logic          exp_trip;
        logic [NM*DW-1:0] exp_duty;
        exp_trip = !m_ever || ((cyc - m_commit_cyc) >= WD);
        for (int k = 0; k < NM; k++) exp_duty[k*DW +: DW] = exp_trip ? '0 : m_duty[k];
        check_eq({tag, ".duty"}, 64'(duty_cycle), 64'(exp_duty));
        check_eq({tag, ".dir"}, 64'(direction), 64'(m_dir));
        check_eq({tag, ".trip"}, 64'(watchdog_trip), 64'(exp_trip));
    endtask

    task automatic clock_bits(input int from, input int upto, input int half, input bit mutate);
        for (int i = from; i < upto; i++) begin
            if (i < FB) spi.spi_mosi = tx_words[i / WW][WW - 1 - (i % WW)];
            else        spi.spi_mosi = 1'($urandom % 2);
            repeat (half) @(negedge clock);
            if (i < FB) miso_bits[FB - 1 - i] = spi.spi_miso;
            spi.spi_sck = 1'b1;
            if (mutate && i == 20) hall_count = 80'({$urandom, $urandom, $urandom});
            repeat (half) @(negedge clock);
            spi.spi_sck = 1'b0;
        end
    endtask

    task automatic send_frame(input int nbits, input int half, input bit mutate);
        int u0, e0, lat;
        bit valid;
        @(negedge clock);
        for (int k = 0; k < NM; k++) hall_snap[k] = hall_count[k*WW +: WW];
        u0 = upd_total;
        e0 = err_total;
        spi.spi_cs_n = 1'b0;
        repeat (half + 2) @(negedge clock);
        clock_bits(0, nbits, half, mutate);
        repeat (half) @(negedge clock);
        spi.spi_cs_n = 1'b1;
        valid = (nbits == FB);
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (update && lat == 0) lat = c;
        end
        check_eq("update_count", 64'(upd_total - u0), 64'(valid));
        check_eq("error_count", 64'(err_total - e0), 64'(!valid));
        check_eq("miso_idle", 64'(spi.spi_miso), 64'd0);
        if (valid) begin
            check_eq("latency_le4", 64'(lat >= 1 && lat <= 4), 64'd1);
            for (int k = 0; k < NM; k++) begin
                m_duty[k] = tx_words[k][DW-1:0];
                m_dir[k]  = tx_words[k][WW-1];
            end
            m_ever       = 1;
            m_commit_cyc = last_upd_cyc;
        end
        if (nbits >= FB) begin
            for (int k = 0; k < NM; k++)
                check_eq($sformatf("miso_word%0d", k),
                         64'(miso_bits[FB - 1 - k*WW -: WW]), 64'(hall_snap[k]));
        end
        check_state("frame");
    endtask

    initial begin
        int u0, e0, nb;
        int lens [7] = '{80, 80, 80, 79, 81, 64, 90};

        spi.spi_sck  = 1'b0;
        spi.spi_cs_n = 1'b1;
        spi.spi_mosi = 1'b0;
        hall_count   = 80'({$urandom, $urandom, $urandom});
        model_reset();
        repeat (5) @(negedge clock);
        check_eq("rst.update", 64'(update), 64'd0);
        check_eq("rst.ferr", 64'(frame_error), 64'd0);
        check_eq("rst.miso", 64'(spi.spi_miso), 64'd0);
        check_state("rst");
        reset_n = 1'b1;
        repeat (5) @(negedge clock);

        // Directed frame with known decode.
        tx_words = '{16'h8005, 16'h0100, 16'h03FF, 16'h0000, 16'h81FF};
        send_frame(FB, 4, 0);
        check_eq("t1.duty_vec", 64'(duty_cycle), 64'({10'h1FF, 10'h000, 10'h3FF, 10'h100, 10'h005}));
        check_eq("t1.dir_vec", 64'(direction), 64'(5'b10001));

        // Snapshot held even though hall_count changes mid-frame.
        hall_count = {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'hABCD};
        send_frame(FB, 4, 1);

        // Short and long frames are discarded.
        send_frame(FB - 1, 4, 0);
        send_frame(FB + 1, 4, 0);

        // Watchdog expiry exactly WD cycles after the commit.
        tx_words = '{16'h0200, 16'h0011, 16'h8022, 16'h0033, 16'h0044};
        send_frame(FB, 4, 0);
        while (cyc < last_upd_cyc + WD - 1) @(negedge clock);
        check_state("wd_before");
        while (cyc < last_upd_cyc + WD) @(negedge clock);
        check_state("wd_at");
        tx_words = '{16'h0123, 16'h0011, 16'h8022, 16'h0033, 16'h0044};
        send_frame(FB, 4, 0);

        // Reset in the middle of a frame, released with cs still low.
        u0 = upd_total;
        e0 = err_total;
        @(negedge clock);
        spi.spi_cs_n = 1'b0;
        repeat (6) @(negedge clock);
        clock_bits(0, 40, 4, 0);
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        check_state("mid_rst");
        clock_bits(40, FB, 4, 0);
        repeat (4) @(negedge clock);
        spi.spi_cs_n = 1'b1;
        repeat (10) @(negedge clock);
        check_eq("mid_rst.update", 64'(upd_total - u0), 64'd0);
        check_eq("mid_rst.ferr", 64'(err_total - e0), 64'd0);
        send_frame(FB, 4, 0);

        // Random frames: reserved bits, lengths and sck rates vary.
        for (int n = 0; n < 10; n++) begin
            for (int k = 0; k < NM; k++) tx_words[k] = 16'($urandom);
            nb = lens[$urandom_range(0, 6)];
            send_frame(nb, $urandom_range(4, 6), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
